// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: decodes ALU-class fields, drives the ALU and returns the result over valid/ready.
// Optional macro ALU_PERF_EN adds saturating op_count/illegal_count handshake counters.
module alu_issue_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic            out_zero,
    output logic            out_illegal
`ifdef ALU_PERF_EN
    ,
    output logic [31:0]     op_count,
    output logic [15:0]     illegal_count
`endif
);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SLL  = 4'b0011;
    localparam logic [3:0] CTRL_SUB  = 4'b0100;
    localparam logic [3:0] CTRL_SRL  = 4'b0101;
    localparam logic [3:0] CTRL_MUL  = 4'b0110;
    localparam logic [3:0] CTRL_XOR  = 4'b0111;
    localparam logic [3:0] CTRL_SLTU = 4'b1000;
    localparam logic [3:0] CTRL_SRA  = 4'b1001;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] in1_q, in1_d, in2_q, in2_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            zero_q, zero_d;
    logic            ill_q, ill_d;
    logic [4:0]      dec;

    // Returns {illegal, ctrl}; funct7_0 only matters for R-type (M-extension).
    function automatic logic [4:0] decode(input logic [1:0] op, input logic [2:0] f3,
                                          input logic f75, input logic f70);
        logic       ill;
        logic [3:0] c;
        logic       rtype;
        ill   = 1'b0;
        c     = CTRL_ADD;
        rtype = (op == 2'b10);
        case (op)
            2'b00: c = CTRL_ADD;
            2'b01: c = CTRL_SUB;
            default: begin
                case (f3)
                    3'b000: begin
                        if (rtype && f70)      c = CTRL_MUL;
                        else if (rtype && f75) c = CTRL_SUB;
                        else                   c = CTRL_ADD;
                    end
                    3'b001: c = CTRL_SLL;
                    3'b010: ill = 1'b1;
                    3'b011: c = CTRL_SLTU;
                    3'b100: c = CTRL_XOR;
                    3'b101: c = f75 ? CTRL_SRA : CTRL_SRL;
                    3'b110: c = CTRL_OR;
                    default: c = CTRL_AND;
                endcase
                if (rtype && f70 && (f3 != 3'b000)) ill = 1'b1;
            end
        endcase
        return {ill, c};
    endfunction

    always_comb begin
        dec     = decode(alu_op, funct3, funct7_5, funct7_0);
        state_d = state_q;
        cnt_d   = cnt_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        ctrl_d  = ctrl_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (dec[4]) begin
                        // Illegal ops bypass the ALU and leave its inputs untouched.
                        state_d = DONE;
                        res_d   = '0;
                        zero_d  = 1'b0;
                        ill_d   = 1'b1;
                    end else begin
                        state_d = EXEC;
                        in1_d   = rs1_data;
                        in2_d   = (alu_op[0] == alu_op[1]) ? imm : rs2_data;
                        ctrl_d  = dec[3:0];
                        cnt_d   = (dec[3:0] == CTRL_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
                        ill_d   = 1'b0;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    res_d   = alu_res;
                    zero_d  = alu_z;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            ctrl_q  <= CTRL_AND;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_ctrl    = ctrl_q;
    assign out_res     = res_q;
    assign out_zero    = zero_q;
    assign out_illegal = ill_q;

`ifdef ALU_PERF_EN
    logic [31:0] op_cnt_q;
    logic [15:0] ill_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt_q  <= '0;
            ill_cnt_q <= '0;
        end else if ((state_q == DONE) && out_ready) begin
            if (ill_q) begin
                if (ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + 16'd1;
            end else begin
                if (op_cnt_q != '1) op_cnt_q <= op_cnt_q + 32'd1;
            end
        end
    end

    assign op_count      = op_cnt_q;
    assign illegal_count = ill_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed requests push expectations, a negedge monitor checks results.
module tb_alu_issue_ctrl;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        funct7_0;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [31:0] alu_in1, alu_in2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_res;
    logic        alu_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_zero;
    logic        out_illegal;
`ifdef ALU_PERF_EN
    logic [31:0] op_count;
    logic [15:0] illegal_count;
`endif

    alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_z(alu_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_zero(out_zero), .out_illegal(out_illegal)
`ifdef ALU_PERF_EN
        , .op_count(op_count), .illegal_count(illegal_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU on the other side of the interface.
    always_comb begin
        alu_res = 32'h0;
        case (alu_ctrl)
            4'b0000: alu_res = alu_in1 & alu_in2;
            4'b0001: alu_res = alu_in1 | alu_in2;
            4'b0010: alu_res = alu_in1 + alu_in2;
            4'b0011: alu_res = alu_in1 << alu_in2[4:0];
            4'b0100: alu_res = alu_in1 - alu_in2;
            4'b0101: alu_res = alu_in1 >> alu_in2[4:0];
            4'b0110: alu_res = alu_in1 * alu_in2;
            4'b0111: alu_res = alu_in1 ^ alu_in2;
            4'b1000: alu_res = {31'h0, (alu_in1 < alu_in2)};
            4'b1001: alu_res = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
            default: alu_res = 32'hDEAD_BEEF;
        endcase
        alu_z = (alu_res == 32'h0);
    end

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        logic [3:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   seen = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: first valid cycle checks latency/result/ALU drive; later cycles check hold stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 expected no pending request (cycle %0d)", cyc);
                end else begin
                    cur  = q.pop_front();
                    seen = 1'b1;
                    chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    chk("out_res", out_res, cur.res);
                    chk("out_zero", {31'h0, out_zero}, {31'h0, cur.zero});
                    chk("out_illegal", {31'h0, out_illegal}, {31'h0, cur.ill});
                    chk("alu_ctrl", {28'h0, alu_ctrl}, {28'h0, cur.ctrl});
                    chk("alu_in1", alu_in1, cur.in1);
                    chk("alu_in2", alu_in2, cur.in2);
                end
            end else begin
                chk("hold_res", out_res, cur.res);
                chk("hold_zero", {31'h0, out_zero}, {31'h0, cur.zero});
                chk("hold_illegal", {31'h0, out_illegal}, {31'h0, cur.ill});
            end
            chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
            if (out_ready) seen = 1'b0;
        end
    end

    // Called at posedge+#1; waits for in_ready, presents one request and records its expectation.
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f75, input logic f70,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] eres, input logic ez, input logic eill,
                         input logic [3:0] ectrl, input logic [31:0] ein1, input logic [31:0] ein2,
                         input int lat);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_wait", {31'h0, in_ready}, 32'h1);
        alu_op   = op;
        funct3   = f3;
        funct7_5 = f75;
        funct7_0 = f70;
        rs1_data = r1;
        rs2_data = r2;
        imm      = im;
        in_valid = 1'b1;
        e.res  = eres;
        e.zero = ez;
        e.ill  = eill;
        e.ctrl = ectrl;
        e.in1  = ein1;
        e.in2  = ein2;
        e.acc  = cyc + 1;
        e.lat  = lat;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1_data = 32'hA5A5_A5A5;
        rs2_data = 32'h5A5A_5A5A;
        imm      = 32'h0F0F_0F0F;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid || !in_ready) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b0;
        rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_res", out_res, 32'h0);
        chk("rst_out_illegal", {31'h0, out_illegal}, 32'h0);
        chk("rst_alu_ctrl", {28'h0, alu_ctrl}, 32'h0);
        chk("rst_alu_in1", alu_in1, 32'h0);
        chk("rst_alu_in2", alu_in2, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //     op     f3      f75   f70   rs1            rs2            imm            res            z     ill   ctrl     in1            in2            lat
        issue(2'b10, 3'b000, 1'b0, 1'b0, 32'd5,         32'd7,         32'd99,        32'd12,        1'b0, 1'b0, 4'b0010, 32'd5,         32'd7,         1);
        issue(2'b01, 3'b000, 1'b0, 1'b0, 32'h1234,      32'h1234,      32'h0,         32'h0,         1'b1, 1'b0, 4'b0100, 32'h1234,      32'h1234,      1);
        issue(2'b11, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h55,        32'd4,         32'hF800_0000, 1'b0, 1'b0, 4'b1001, 32'h8000_0000, 32'd4,         1);
        issue(2'b10, 3'b000, 1'b0, 1'b1, 32'd6,         32'd7,         32'd1,         32'd42,        1'b0, 1'b0, 4'b0110, 32'd6,         32'd7,         MUL_LAT);

        // Illegal SLT under three cycles of backpressure; ALU drive keeps the MUL values.
        wait_drain();
        out_ready = 1'b0;
        issue(2'b10, 3'b010, 1'b0, 1'b0, 32'd99,        32'd98,        32'd97,        32'h0,         1'b0, 1'b1, 4'b0110, 32'd6,         32'd7,         0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
        chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;

        issue(2'b00, 3'b111, 1'b1, 1'b1, 32'h1000,      32'hDEAD,      32'h10,        32'h1010,      1'b0, 1'b0, 4'b0010, 32'h1000,      32'h10,        1);
        issue(2'b11, 3'b000, 1'b1, 1'b1, 32'd3,         32'd50,        32'hFFFF_FFFD, 32'h0,         1'b1, 1'b0, 4'b0010, 32'd3,         32'hFFFF_FFFD, 1);
        issue(2'b10, 3'b000, 1'b1, 1'b0, 32'd10,        32'd3,         32'd0,         32'd7,         1'b0, 1'b0, 4'b0100, 32'd10,        32'd3,         1);
        issue(2'b10, 3'b011, 1'b0, 1'b0, 32'd1,         32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 1'b0, 4'b1000, 32'd1,         32'hFFFF_FFFF, 1);
        issue(2'b11, 3'b100, 1'b0, 1'b0, 32'hFF00_FF00, 32'd0,         32'h0000_0FF0, 32'hFF00_F0F0, 1'b0, 1'b0, 4'b0111, 32'hFF00_FF00, 32'h0000_0FF0, 1);
        issue(2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd31,        32'd0,         32'd1,         1'b0, 1'b0, 4'b0101, 32'h8000_0000, 32'd31,        1);
        issue(2'b10, 3'b001, 1'b0, 1'b0, 32'd1,         32'd4,         32'd0,         32'd16,        1'b0, 1'b0, 4'b0011, 32'd1,         32'd4,         1);
        issue(2'b10, 3'b110, 1'b0, 1'b0, 32'hF0,        32'h0F,        32'd0,         32'hFF,        1'b0, 1'b0, 4'b0001, 32'hF0,        32'h0F,        1);
        issue(2'b10, 3'b111, 1'b0, 1'b0, 32'hF0,        32'h0F,        32'd0,         32'h0,         1'b1, 1'b0, 4'b0000, 32'hF0,        32'h0F,        1);
        issue(2'b10, 3'b100, 1'b0, 1'b1, 32'd11,        32'd12,        32'd13,        32'h0,         1'b0, 1'b1, 4'b0000, 32'hF0,        32'h0F,        0);
        issue(2'b11, 3'b010, 1'b0, 1'b0, 32'd11,        32'd12,        32'd13,        32'h0,         1'b0, 1'b1, 4'b0000, 32'hF0,        32'h0F,        0);
        wait_drain();
`ifdef ALU_PERF_EN
        chk("op_count", op_count, 32'd13);
        chk("illegal_count", {16'h0, illegal_count}, 32'd3);
`endif

        // Reset while a MUL is still in EXEC; its result must never appear.
        issue(2'b10, 3'b000, 1'b0, 1'b1, 32'd9,         32'd9,         32'd0,         32'd81,        1'b0, 1'b0, 4'b0110, 32'd9,         32'd9,         MUL_LAT);
        chk("mid_mul_in_ready", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("mid_rst_alu_ctrl", {28'h0, alu_ctrl}, 32'h0);
        chk("mid_rst_out_res", out_res, 32'h0);
        chk("mid_rst_alu_in1", alu_in1, 32'h0);
`ifdef ALU_PERF_EN
        chk("mid_rst_op_count", op_count, 32'h0);
        chk("mid_rst_illegal_count", {16'h0, illegal_count}, 32'h0);
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle", {31'h0, out_valid}, 32'h0);
        end

        issue(2'b10, 3'b000, 1'b0, 1'b0, 32'd100,       32'd23,        32'd0,         32'd123,       1'b0, 1'b0, 4'b0010, 32'd100,       32'd23,        1);
        wait_drain();
`ifdef ALU_PERF_EN
        chk("final_op_count", op_count, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Execute-stage producer for the ALU operand/control interface. It decodes RISC-V ALU-class instruction fields into the 4-bit alu_ctrl encoding, registers the operands and drives them to the combinational ALU. It captures res/z_flg back and presents the result through a valid/ready handshake. It sits between decode/register-read and writeback, and owns multi-cycle waiting for MULTIPLY.

Parameters:
MUL_LAT, 2, cycles alu_ctrl=0110 is held before capture; legal range 1..15.
XLEN, 32, operand/result width; fixed at 32 to match the ALU.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream request valid
in_ready  output  1  high when the block can accept a request (state IDLE)
alu_op  input  2  00 load/store address, 01 branch compare, 10 R-type, 11 I-type
funct3  input  3  instruction funct3
funct7_5  input  1  instruction bit 30
funct7_0  input  1  instruction bit 25 (M-extension select)
rs1_data  input  32  source operand 1
rs2_data  input  32  source operand 2
imm  input  32  sign-extended immediate
alu_in1  output  32  registered operand to ALU in1
alu_in2  output  32  registered operand to ALU in2
alu_ctrl  output  4  registered ALU function select
alu_res  input  32  ALU res
alu_z  input  1  ALU z_flg
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_res  output  32  captured result
out_zero  output  1  captured zero flag
out_illegal  output  1  request decoded as unsupported

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE. in_ready=1 after reset. out_valid=0, out_res=0, out_zero=0, out_illegal=0, alu_in1=0, alu_in2=0, alu_ctrl=0000, wait counter=0. Reset overrides any in-flight operation; the pending result is discarded.
- States:
  - IDLE: accept on in_valid&&in_ready.
  - EXEC: ALU inputs are stable.
  - DONE: out_valid=1 until out_ready.
- Decode, alu_op=00: ctrl=0010 (ADD), in2=imm.
- Decode, alu_op=01: ctrl=0100 (SUB), in2=rs2_data.
- Decode, alu_op=10 (R-type), in2=rs2_data:
  - funct3 000: funct7_0=1 gives 0110 (MUL); otherwise funct7_5 selects 0100 (SUB) or 0010 (ADD).
  - funct3 001 gives 0011. 011 gives 1000 (unsigned SLTU). 100 gives 0111. 101 gives 1001 if funct7_5=1, else 0101. 110 gives 0001. 111 gives 0000.
  - Illegal: funct3 010 (signed SLT is unsupported), or funct7_0=1 with funct3≠000.
- Decode, alu_op=11 (I-type): same map as R-type except funct3 000 is always ADD, funct7_0 is ignored, and funct3 010 is illegal. in2=imm.
- in1 is always rs1_data.
- Accept at edge k, legal op: operands and ctrl are registered and state goes to EXEC.
  - Non-MUL: capture alu_res/alu_z at edge k+1 and go to DONE. out_valid is first high in cycle k+1.
  - MUL: hold EXEC for MUL_LAT cycles, capture at edge k+MUL_LAT.
- Accept of an illegal op: go directly to DONE at edge k with out_illegal=1, out_res=0, out_zero=0. alu_ctrl and operands are left unchanged.
- DONE: out_res, out_zero and out_illegal hold stable while out_valid=1 and out_ready=0. On out_ready=1, return to IDLE at that edge and clear out_valid.
- in_ready is low in EXEC and DONE, so there is no overlap. Input fields are sampled only at accept.
- alu_ctrl and operands hold their last value after capture; they do not return to zero.

Optional Feature:
ALU_PERF_EN:
- Defined: adds output op_count[31:0] and output illegal_count[15:0].
  - op_count counts DONE-to-IDLE handshakes of legal ops; illegal_count counts those of illegal ops.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; everything else is identical.

Test Plan:
- ADD: alu_op=10, funct3=000, rs1=5, rs2=7, out_ready=1 -> alu_ctrl=0010, out_valid one cycle after accept, out_res=12, out_zero=0.
- BEQ-style SUB: alu_op=01, rs1=rs2=0x1234 -> alu_ctrl=0100, out_res=0, out_zero=1.
- SRAI: alu_op=11, funct3=101, funct7_5=1, rs1=0x80000000, imm=4 -> alu_ctrl=1001. out_res equals the ALU's returned value; check capture, not arithmetic.
- MUL: funct7_0=1, rs1=6, rs2=7, MUL_LAT=2 -> in_ready low, out_valid first high exactly 2 cycles after accept, out_res=42.
- Backpressure and illegal: funct3=010 R-type with out_ready=0 for 3 cycles -> out_valid=1, out_illegal=1, out_res=0 held stable; in_ready low until the handshake.
- Reset mid-MUL: drive rst_n=0 in the EXEC cycle -> next cycle out_valid=0, in_ready=1, alu_ctrl=0000; with ALU_PERF_EN, op_count=0.
